noc_local_egress_framer: RTL and testbench

//  Frames outbound scratchpad traffic into NoC packets for the tile's local switch port (stream_in_local_in_*).

---
 rtl/noc_local_egress_framer_pkg.sv | 25 ++
 rtl/noc_local_egress_framer_if.sv | 34 +++
 rtl/noc_local_egress_framer_sync_fifo_fwft.sv | 54 +++++
 rtl/noc_local_egress_framer.sv | 116 +++++++++++
 tb/tb_noc_local_egress_framer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_local_egress_framer_pkg.sv
// Shared NoC egress definitions: field widths, header layout and framer FSM states.
package noc_pkg;

   localparam int BW      = 32;
   localparam int BWB     = BW / 8;
   localparam int XY_SZ   = 3;
   localparam int LEN_W   = 16;
   localparam int FIFO_AW = 4;
   localparam int RSVD_W  = BW - LEN_W - 4 * XY_SZ;

   // Field order, MSB first: len occupies [BW-1:BW-LEN_W], dest sits in the low bits.
   typedef struct packed {
      logic [LEN_W-1:0]   len;
      logic [RSVD_W-1:0]  rsvd;
      logic [2*XY_SZ-1:0] src;
      logic [2*XY_SZ-1:0] dest;
   } noc_hdr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      PAY  = 2'd2
   } egress_state_t;

endpackage

// File: rtl/noc_local_egress_framer_if.sv
// Command, payload and outbound flit channels of the local egress framer.
// Every channel is valid/ready: a beat transfers on a clock edge where both are high;
// once valid is raised its payload stays stable until that transfer happens.
interface noc_local_egress_framer_if;
   import noc_pkg::*;

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [2*XY_SZ-1:0]   cmd_dest;
   logic [LEN_W-1:0]     cmd_len;

   logic                 pl_TVALID;
   logic [BW-1:0]        pl_TDATA;
   logic                 pl_TREADY;

   logic                 stream_out_TVALID;
   logic [BW-1:0]        stream_out_TDATA;
   logic [BWB-1:0]       stream_out_TKEEP;
   logic                 stream_out_TLAST;
   logic                 stream_out_TREADY;

   modport slave (
      input  cmd_valid, cmd_dest, cmd_len, pl_TVALID, pl_TDATA, stream_out_TREADY,
      output cmd_ready, pl_TREADY, stream_out_TVALID, stream_out_TDATA,
      output stream_out_TKEEP, stream_out_TLAST
   );

   modport master (
      output cmd_valid, cmd_dest, cmd_len, pl_TVALID, pl_TDATA, stream_out_TREADY,
      input  cmd_ready, pl_TREADY, stream_out_TVALID, stream_out_TDATA,
      input  stream_out_TKEEP, stream_out_TLAST
   );

endinterface

// File: rtl/noc_local_egress_framer_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; data_o shows the head whenever empty_o is low.
module sync_fifo_fwft #(
   parameter int WIDTH = 32,
   parameter int AW    = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   localparam int DEPTH = 2 ** AW;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when the indices coincide.
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign full_o  = (count_o == DEPTH[AW:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/noc_local_egress_framer.sv
// Frames buffered accelerator payload into NoC packets: one header flit, then len payload flits.
module noc_local_egress_framer
   import noc_pkg::*;
(
   input  logic                  clk_line,
   input  logic                  clk_line_rst_low,
   input  logic [2*XY_SZ-1:0]    HsrcId,
   noc_local_egress_framer_if.slave bus,
   output logic                  busy,
   output logic [31:0]           pkt_count,
   output egress_state_t         state_dbg_o,
   output logic [FIFO_AW:0]      fifo_count_dbg_o
);

   egress_state_t    state_q, state_d;
   noc_hdr_t         hdr_q, hdr_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [31:0]      pkt_cnt_q, pkt_cnt_d;
   logic             en_q;

   logic             fifo_full, fifo_empty, fifo_pop, fifo_push;
   logic [BW-1:0]    fifo_head;
   logic             cmd_rdy, out_valid, out_last;
   logic [BW-1:0]    out_data;

   // en_q keeps the ready outputs low while reset is held and for the first edge after release.
   assign bus.pl_TREADY = en_q && !fifo_full;
   assign fifo_push     = bus.pl_TVALID && bus.pl_TREADY;

   sync_fifo_fwft #(.WIDTH(BW), .AW(FIFO_AW)) u_fifo (
      .clk_i   (clk_line),
      .rst_ni  (clk_line_rst_low),
      .push_i  (fifo_push),
      .data_i  (bus.pl_TDATA),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count_dbg_o)
   );

   always_comb begin
      state_d   = state_q;
      hdr_d     = hdr_q;
      rem_d     = rem_q;
      pkt_cnt_d = pkt_cnt_q;
      cmd_rdy   = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      fifo_pop  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cmd_rdy = en_q;
            if (bus.cmd_valid && en_q) begin
               hdr_d   = '{len: bus.cmd_len, rsvd: '0, src: HsrcId, dest: bus.cmd_dest};
               state_d = HDR;
            end
         end
         HDR: begin
            out_valid = 1'b1;
            out_data  = hdr_q;
            out_last  = (hdr_q.len == '0);
            if (bus.stream_out_TREADY) begin
               if (hdr_q.len == '0) begin
                  state_d   = IDLE;
                  pkt_cnt_d = pkt_cnt_q + 32'd1;
               end else begin
                  rem_d   = hdr_q.len;
                  state_d = PAY;
               end
            end
         end
         PAY: begin
            out_valid = !fifo_empty;
            out_data  = fifo_empty ? '0 : fifo_head;
            out_last  = !fifo_empty && (rem_q == LEN_W'(1));
            if (out_valid && bus.stream_out_TREADY) begin
               fifo_pop = 1'b1;
               rem_d    = rem_q - 1'b1;
               if (rem_q == LEN_W'(1)) begin
                  state_d   = IDLE;
                  pkt_cnt_d = pkt_cnt_q + 32'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
      if (!clk_line_rst_low) begin
         state_q   <= IDLE;
         hdr_q     <= '0;
         rem_q     <= '0;
         pkt_cnt_q <= '0;
         en_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         hdr_q     <= hdr_d;
         rem_q     <= rem_d;
         pkt_cnt_q <= pkt_cnt_d;
         en_q      <= 1'b1;
      end
   end

   assign bus.cmd_ready         = cmd_rdy;
   assign bus.stream_out_TVALID = out_valid;
   assign bus.stream_out_TDATA  = out_data;
   assign bus.stream_out_TLAST  = out_last;
   assign bus.stream_out_TKEEP  = {BWB{out_valid}};
   assign busy                  = (state_q != IDLE);
   assign pkt_count             = pkt_cnt_q;
   assign state_dbg_o           = state_q;

endmodule

// File: tb/tb_noc_local_egress_framer.sv
// Directed bench for the local egress framer: scoreboarded flits, hold-stability and reset checks.
module tb_noc_local_egress_framer;
   import noc_pkg::*;

   logic               clk_line = 1'b0;
   logic               clk_line_rst_low;
   logic [2*XY_SZ-1:0] HsrcId;
   logic               busy;
   logic [31:0]        pkt_count;
   egress_state_t      state_dbg;
   logic [FIFO_AW:0]   fifo_count;
   logic               tb_tready = 1'b1;
   bit                 bp_en = 1'b0;
   bit                 sb_en = 1'b1;

   int                 n_chk = 0;
   int                 n_fail = 0;
   int                 pay_beats = 0;
   logic [32:0]        exp_q[$];
   logic [32:0]        exp_e;
   logic [32:0]        held;
   logic               stall_q = 1'b0;

   noc_local_egress_framer_if bus();
   assign bus.stream_out_TREADY = tb_tready;

   noc_local_egress_framer dut (
      .clk_line         (clk_line),
      .clk_line_rst_low (clk_line_rst_low),
      .HsrcId           (HsrcId),
      .bus              (bus),
      .busy             (busy),
      .pkt_count        (pkt_count),
      .state_dbg_o      (state_dbg),
      .fifo_count_dbg_o (fifo_count)
   );

   // clock / reset block
   always #5 clk_line = ~clk_line;

   always @(posedge clk_line) begin
      #1;
      tb_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no end of test, required end within 2 ms");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard / monitor: sampled on the falling edge, away from the active edge
   always @(negedge clk_line) begin
      if (!clk_line_rst_low) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            chk("hold_valid", bus.stream_out_TVALID, 1);
            chk("hold_flit", {bus.stream_out_TLAST, bus.stream_out_TDATA}, held);
         end
         if (bus.stream_out_TVALID && bus.stream_out_TREADY) begin
            if (state_dbg == PAY) pay_beats++;
            if (sb_en) begin
               if (exp_q.size() == 0) begin
                  chk("extra_flit_q_size", exp_q.size(), 1);
               end else begin
                  exp_e = exp_q.pop_front();
                  chk("flit", {bus.stream_out_TLAST, bus.stream_out_TDATA}, exp_e);
                  chk("tkeep", bus.stream_out_TKEEP, 4'hF);
               end
            end
            stall_q = 1'b0;
         end else if (bus.stream_out_TVALID) begin
            stall_q = 1'b1;
            held    = {bus.stream_out_TLAST, bus.stream_out_TDATA};
         end else begin
            stall_q = 1'b0;
         end
      end
   end

   // driver tasks: entered and left just after a rising edge
   task automatic push_word(input logic [31:0] w);
      int t = 0;
      bus.pl_TVALID = 1'b1;
      bus.pl_TDATA  = w;
      @(negedge clk_line);
      while (!bus.pl_TREADY && t < 500) begin
         t++;
         @(negedge clk_line);
      end
      if (t >= 500) chk("push_timeout_cycles", t, 0);
      @(posedge clk_line);
      #1;
      bus.pl_TVALID = 1'b0;
   endtask

   task automatic send_cmd(input logic [5:0] dest, input logic [15:0] len);
      int t = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_dest  = dest;
      bus.cmd_len   = len;
      @(negedge clk_line);
      while (!bus.cmd_ready && t < 500) begin
         t++;
         @(negedge clk_line);
      end
      if (t >= 500) chk("cmd_timeout_cycles", t, 0);
      @(posedge clk_line);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while ((exp_q.size() != 0 || busy) && t < 3000) begin
         t++;
         @(negedge clk_line);
      end
      if (t >= 3000) chk("drain_timeout_cycles", t, 0);
      @(posedge clk_line);
      #1;
   endtask

   initial begin
      int cnt;
      int t;
      int base;
      clk_line_rst_low = 1'b0;
      HsrcId           = 6'o12;
      bus.cmd_valid    = 1'b0;
      bus.cmd_dest     = '0;
      bus.cmd_len      = '0;
      bus.pl_TVALID    = 1'b0;
      bus.pl_TDATA     = '0;

      // 1: reset values, then readiness after release
      #12;
      @(negedge clk_line);
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      chk("rst_pl_tready", bus.pl_TREADY, 0);
      chk("rst_tvalid", bus.stream_out_TVALID, 0);
      chk("rst_tlast", bus.stream_out_TLAST, 0);
      chk("rst_tkeep", bus.stream_out_TKEEP, 0);
      chk("rst_tdata", bus.stream_out_TDATA, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pkt_count", pkt_count, 0);
      @(posedge clk_line);
      #1;
      clk_line_rst_low = 1'b1;
      @(posedge clk_line);
      @(negedge clk_line);
      chk("post_rst_cmd_ready", bus.cmd_ready, 1);
      chk("post_rst_pl_tready", bus.pl_TREADY, 1);
      chk("post_rst_pkt_count", pkt_count, 0);
      @(posedge clk_line);
      #1;

      // 2: basic 3-word packet; src 6'o12 lands in [11:6], dest 6'o34 in [5:0]
      push_word(32'h0000_00A0);
      push_word(32'h0000_00A1);
      push_word(32'h0000_00A2);
      exp_q.push_back({1'b0, 32'h0003_029C});
      exp_q.push_back({1'b0, 32'h0000_00A0});
      exp_q.push_back({1'b0, 32'h0000_00A1});
      exp_q.push_back({1'b1, 32'h0000_00A2});
      send_cmd(6'o34, 16'd3);
      cnt = 0;
      t   = 0;
      @(negedge clk_line);
      while (!bus.cmd_ready && t < 100) begin
         cnt++;
         t++;
         @(negedge clk_line);
      end
      chk("cmd_ready_low_cycles", cnt, 4);
      wait_done();
      chk("pkt_count_t2", pkt_count, 1);

      // 3: header-only packet leaves a queued word in place
      push_word(32'h3333_0001);
      exp_q.push_back({1'b1, 32'h0000_0285});
      send_cmd(6'o05, 16'd0);
      wait_done();
      chk("fifo_untouched", fifo_count, 1);
      chk("pkt_count_t3a", pkt_count, 2);
      exp_q.push_back({1'b0, 32'h0001_0285});
      exp_q.push_back({1'b1, 32'h3333_0001});
      send_cmd(6'o05, 16'd1);
      wait_done();
      chk("pkt_count_t3b", pkt_count, 3);
      chk("fifo_empty_t3", fifo_count, 0);

      // 4: full FIFO, random backpressure on the flit side
      for (int i = 0; i < 16; i++) push_word(32'h4000_0000 + i);
      @(negedge clk_line);
      chk("full_pl_tready", bus.pl_TREADY, 0);
      chk("full_count", fifo_count, 16);
      @(posedge clk_line);
      #1;
      bp_en = 1'b1;
      exp_q.push_back({1'b0, 32'h0010_02BF});
      for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), 32'h4000_0000 + i});
      send_cmd(6'o77, 16'd16);
      t = 0;
      while (!(state_dbg == PAY && bus.stream_out_TVALID && bus.stream_out_TREADY) && t < 500) begin
         t++;
         @(negedge clk_line);
      end
      if (t >= 500) chk("first_pop_timeout_cycles", t, 0);
      @(negedge clk_line);
      chk("pl_tready_after_pop", bus.pl_TREADY, 1);
      wait_done();
      bp_en = 1'b0;
      chk("pkt_count_t4", pkt_count, 4);

      // 5: excess payload carried into the following packet
      for (int i = 0; i < 5; i++) push_word(32'h5000_0000 + i);
      exp_q.push_back({1'b0, 32'h0002_0281});
      exp_q.push_back({1'b0, 32'h5000_0000});
      exp_q.push_back({1'b1, 32'h5000_0001});
      exp_q.push_back({1'b0, 32'h0003_0281});
      exp_q.push_back({1'b0, 32'h5000_0002});
      exp_q.push_back({1'b0, 32'h5000_0003});
      exp_q.push_back({1'b1, 32'h5000_0004});
      send_cmd(6'o01, 16'd2);
      send_cmd(6'o01, 16'd3);
      wait_done();
      chk("pkt_count_t5", pkt_count, 6);
      chk("fifo_empty_t5", fifo_count, 0);

      // 6: reset after two of eight payload beats
      for (int i = 0; i < 8; i++) push_word(32'h6000_0000 + i);
      sb_en = 1'b0;
      base  = pay_beats;
      send_cmd(6'o02, 16'd8);
      t = 0;
      while ((pay_beats - base) < 2 && t < 500) begin
         t++;
         @(negedge clk_line);
      end
      if (t >= 500) chk("mid_pay_timeout_cycles", t, 0);
      @(posedge clk_line);
      #1;
      clk_line_rst_low = 1'b0;
      #1;
      chk("midrst_tvalid", bus.stream_out_TVALID, 0);
      chk("midrst_tkeep", bus.stream_out_TKEEP, 0);
      chk("midrst_tdata", bus.stream_out_TDATA, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_state", state_dbg, IDLE);
      chk("midrst_fifo", fifo_count, 0);
      chk("midrst_cmd_ready", bus.cmd_ready, 0);
      chk("midrst_pl_tready", bus.pl_TREADY, 0);
      chk("midrst_pkt_count", pkt_count, 0);
      @(posedge clk_line);
      #1;
      clk_line_rst_low = 1'b1;
      @(posedge clk_line);
      #1;
      sb_en = 1'b1;
      push_word(32'h7777_0000);
      exp_q.push_back({1'b0, 32'h0001_0282});
      exp_q.push_back({1'b1, 32'h7777_0000});
      send_cmd(6'o02, 16'd1);
      wait_done();
      chk("pkt_count_t6", pkt_count, 1);
      chk("fifo_empty_t6", fifo_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
